// File: rtl/bound_flasher_param.sv
// bound_flasher_param
//   Drives an N_LED thermometer bar through a table of alternating up/down
//   bound phases. A flick starts a run from idle, or, at a kick point during
//   a falling phase, throws the bar back into the preceding rising phase.
//   A prescaler sets how many clocks each level step takes, and loop mode
//   restarts the table instead of returning to idle.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   flick   in   start / kickback request, sampled at the clock edge
//   loop_en in   1 = restart phase 0 after the last phase instead of idling
//   led     out  thermometer bar, led[j] = (j < level)
//   level   out  current lit count (0..N_LED)
//   phase   out  current phase index
//   busy    out  high while a run is in progress
//   done    out  one-cycle pulse when the last phase completes
module bound_flasher_param #(
  parameter int N_LED = 16,
  parameter int N_PHASE = 6,
  localparam int LW = $clog2(N_LED + 1),
  localparam int PW = ($clog2(N_PHASE) > 1) ? $clog2(N_PHASE) : 1,
  parameter logic [N_PHASE*LW-1:0] PHASE_TARGETS = {5'd0, 5'd6, 5'd0, 5'd11, 5'd5, 5'd16},
  parameter logic [N_LED:0] KICK_POINTS = 17'h00021,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flick,
  input  logic             loop_en,
  output logic [N_LED-1:0] led,
  output logic [LW-1:0]    level,
  output logic [PW-1:0]    phase,
  output logic             busy,
  output logic             done
);

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASE - 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(N_LED);

  // Bad parameter sets are rejected while elaborating, not discovered on the bench.
  generate
    if (STEP_DIV < 1) begin : g_bad_div
      $error("bound_flasher_param: STEP_DIV must be at least 1");
    end
    for (genvar i = 0; i < N_PHASE; i++) begin : g_chk_target
      if (int'(PHASE_TARGETS[i*LW +: LW]) > N_LED) begin : g_bad_target
        $error("bound_flasher_param: phase target exceeds N_LED");
      end
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] div_q, div_d;
  logic          done_q, done_d;

  logic [LW-1:0] target;
  logic          kick_here;
  logic          is_down;
  logic          tick;
  logic          kick;
  logic [LW-1:0] level_up;
  logic [LW-1:0] level_dn;

  // Table and kick-mask lookups are written as decoders so that index
  // values the registers can hold but never reach stay out of range checks.
  always_comb begin
    target = '0;
    for (int i = 0; i < N_PHASE; i++) begin
      if (phase_q == PW'(i)) target = PHASE_TARGETS[i*LW +: LW];
    end
    kick_here = 1'b0;
    for (int k = 0; k <= N_LED; k++) begin
      if (level_q == LW'(k)) kick_here = KICK_POINTS[k];
    end
  end

  // Odd phases fall, even phases rise. Steps saturate so the level can
  // never leave 0..N_LED even with a degenerate target table.
  always_comb begin
    is_down  = phase_q[0];
    tick     = (div_q == DIV_LAST);
    kick     = flick && is_down && (phase_q != LAST_PHASE) && kick_here;
    level_up = (level_q == LEVEL_MAX) ? level_q : level_q + LW'(1);
    level_dn = (level_q == '0) ? level_q : level_q - LW'(1);
  end

  // State register: everything the outputs depend on lives here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      phase_q <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. A kickback is checked on every running cycle and
  // beats both a normal step and the end-of-phase transition, so a kick
  // at the last level of a falling phase never produces an advance or done.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    phase_d = phase_q;
    div_d   = div_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = '0;
        phase_d = '0;
        div_d   = '0;
        if (flick) begin
          state_d = RUN;
          level_d = LW'(1);
        end
      end
      RUN: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (kick) begin
          phase_d = phase_q - PW'(1);
          level_d = level_up;
          div_d   = '0;
        end else if (tick) begin
          if (level_q != target) begin
            level_d = is_down ? level_dn : level_up;
          end else if (phase_q != LAST_PHASE) begin
            phase_d = phase_q + PW'(1);
            level_d = is_down ? level_up : level_dn;
          end else begin
            done_d = 1'b1;
            if (loop_en) begin
              phase_d = '0;
              level_d = LW'(1);
            end else begin
              state_d = IDLE;
              phase_d = '0;
              level_d = '0;
              div_d   = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure functions of the registers.
  always_comb begin
    for (int j = 0; j < N_LED; j++) begin
      led[j] = (j < int'(level_q));
    end
    level = level_q;
    phase = phase_q;
    busy  = (state_q == RUN);
    done  = done_q;
  end

endmodule

// File: tb/tb_bound_flasher_param.sv
// tb_bound_flasher_param
//   Runs two flashers side by side (prescaler 1 and prescaler 4) from the
//   same inputs. Expected outputs come from a level/phase model built from
//   the bound table, queued at stimulus time and popped by an independent
//   monitor after every clock edge.
module tb_bound_flasher_param;

  localparam int NLED = 16;
  localparam int NPH  = 6;
  localparam int LWB  = 5;
  localparam int PWB  = 3;

  logic clk = 1'b0;
  logic rst, flick, loop_en;
  logic [NLED-1:0] led0, led4;
  logic [LWB-1:0]  level0, level4;
  logic [PWB-1:0]  phase0, phase4;
  logic busy0, busy4, done0, done4;

  always #5 clk = ~clk;

  bound_flasher_param dut0 (
    .clk(clk), .rst(rst), .flick(flick), .loop_en(loop_en),
    .led(led0), .level(level0), .phase(phase0), .busy(busy0), .done(done0)
  );

  bound_flasher_param #(.STEP_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .flick(flick), .loop_en(loop_en),
    .led(led4), .level(level4), .phase(phase4), .busy(busy4), .done(done4)
  );

  typedef struct packed {
    logic [NLED-1:0] led;
    logic [LWB-1:0]  level;
    logic [PWB-1:0]  phase;
    logic            busy;
    logic            done;
  } obs_t;

  obs_t exp_q0[$];
  obs_t exp_q4[$];

  int assertions = 0;
  int failures   = 0;

  // Bound table and kick levels of the default configuration.
  int targets[NPH] = '{16, 5, 11, 0, 6, 0};
  int step_div[2]  = '{1, 4};

  int m_run[2];
  int m_phase[2];
  int m_level[2];
  int m_div[2];
  int m_done[2];

  // Advance the reference flasher i across one clock edge.
  task automatic model_step(input int i, input logic r, input logic f, input logic lp);
    int dir;
    bit tick;
    m_done[i] = 0;
    if (r) begin
      m_run[i] = 0; m_phase[i] = 0; m_level[i] = 0; m_div[i] = 0;
    end else if (m_run[i] == 0) begin
      if (f) begin
        m_run[i] = 1; m_phase[i] = 0; m_level[i] = 1; m_div[i] = 0;
      end
    end else begin
      dir  = (m_phase[i] % 2 == 0) ? 1 : -1;
      tick = (m_div[i] == step_div[i] - 1);
      m_div[i] = tick ? 0 : m_div[i] + 1;
      if (f && dir < 0 && m_phase[i] != NPH - 1 && (m_level[i] == 0 || m_level[i] == 5)) begin
        m_phase[i] = m_phase[i] - 1;
        m_level[i] = m_level[i] + 1;
        m_div[i]   = 0;
      end else if (tick) begin
        if (m_level[i] != targets[m_phase[i]]) begin
          m_level[i] = m_level[i] + dir;
        end else if (m_phase[i] < NPH - 1) begin
          m_phase[i] = m_phase[i] + 1;
          m_level[i] = m_level[i] - dir;
        end else begin
          m_done[i] = 1;
          if (lp) begin
            m_phase[i] = 0; m_level[i] = 1;
          end else begin
            m_run[i] = 0; m_phase[i] = 0; m_level[i] = 0; m_div[i] = 0;
          end
        end
      end
      if (m_level[i] < 0) m_level[i] = 0;
      if (m_level[i] > NLED) m_level[i] = NLED;
    end
  endtask

  function automatic obs_t model_obs(input int i);
    obs_t e;
    e.led   = NLED'((64'd1 << m_level[i]) - 64'd1);
    e.level = LWB'(m_level[i]);
    e.phase = PWB'(m_phase[i]);
    e.busy  = (m_run[i] != 0);
    e.done  = (m_done[i] != 0);
    return e;
  endfunction

  // Drive one cycle of inputs, queue what both flashers must show after
  // the coming edge, then wait for the following falling edge.
  task automatic applyStimulus(input logic r, input logic f, input logic lp);
    rst = r; flick = f; loop_en = lp;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, f, lp);
      if (i == 0) exp_q0.push_back(model_obs(i));
      else        exp_q4.push_back(model_obs(i));
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input obs_t got, input obs_t want);
    assertions++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s @%0t: got led=%h level=%0d phase=%0d busy=%b done=%b, expected led=%h level=%0d phase=%0d busy=%b done=%b",
               name, $time, got.led, got.level, got.phase, got.busy, got.done,
               want.led, want.level, want.phase, want.busy, want.done);
    end
  endtask

  task automatic check_value(input string name, input int got, input int want);
    assertions++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: every edge, compare each flasher against its queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) checkOutput("dut0", {led0, level0, phase0, busy0, done0}, exp_q0.pop_front());
      if (exp_q4.size() > 0) checkOutput("dut4", {led4, level4, phase4, busy4, done4}, exp_q4.pop_front());
    end
  end

  // Stimulus sequence.
  initial begin
    int  done_edge;
    int  done_count;
    bit  k1, k3, found;
    logic f, lp;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    check_value("reset level", int'(level0), 0);
    check_value("reset busy", int'(busy0), 0);

    // Plain run: level 1 right after the start edge, done exactly at edge 56.
    applyStimulus(1'b0, 1'b1, 1'b0);
    check_value("level after start", int'(level0), 1);
    done_edge = -1;
    for (int k = 1; k <= 70; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (done0 && done_edge < 0) done_edge = k;
    end
    check_value("done edge", done_edge, 56);
    check_value("busy after run", int'(busy0), 0);

    // Kickbacks at (1,5) and (3,0), plus flicks that must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    k1 = 0; k3 = 0; done_count = 0;
    for (int k = 0; k < 130; k++) begin
      f = 1'b0;
      if (m_phase[0] == 1 && m_level[0] == 5 && !k1) begin f = 1'b1; k1 = 1; end
      else if (m_phase[0] == 3 && m_level[0] == 0 && !k3) begin f = 1'b1; k3 = 1; end
      else if (m_phase[0] == 0 && m_level[0] == 5) f = 1'b1;
      else if (m_phase[0] == 5 && m_level[0] == 0) f = 1'b1;
      else if (m_phase[0] == 1 && m_level[0] == 7) f = 1'b1;
      applyStimulus(1'b0, f, 1'b0);
      if (done0) done_count++;
    end
    check_value("kick run done pulses", done_count, 1);

    // Loop mode: two full passes, then let it finish.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    done_count = 0;
    for (int k = 0; k < 125; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (done0) done_count++;
    end
    check_value("loop done pulses", done_count, 2);
    check_value("loop busy", int'(busy0), 1);
    for (int k = 0; k < 60; k++) applyStimulus(1'b0, 1'b0, 1'b0);

    // Prescaled flasher: reset at level 9 of phase 0.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_run[1] != 0 && m_phase[1] == 0 && m_level[1] == 9) found = 1;
      else applyStimulus(1'b0, 1'b0, 1'b0);
    end
    check_value("dut4 reached level 9", int'(found), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check_value("dut4 level after reset", int'(level4), 0);
    check_value("dut4 busy after reset", int'(busy4), 0);
    check_value("dut4 done after reset", int'(done4), 0);

    // Random traffic.
    lp = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) lp = ~lp;
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0), lp);
    end

    @(posedge clk);
    #2;
    check_value("dut0 queue drained", exp_q0.size(), 0);
    check_value("dut4 queue drained", exp_q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
